// File: rtl/chaotic_iter_ctrl.sv
// Feedback sequencer for the x/y/z chaotic stages. Period is L+2 cycles per iteration, with one issue triple in flight.
// There is no backpressure: a result is accepted whenever it is presented in WAIT, and start is ignored while busy.
module chaotic_iter_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed_x,
    input  logic [DATA_WIDTH-1:0] seed_y,
    input  logic [DATA_WIDTH-1:0] seed_z,
    input  logic [CNT_WIDTH-1:0]  warmup,
    input  logic [CNT_WIDTH-1:0]  num_iter,
    output logic                  xn_valid,
    output logic                  yn_valid,
    output logic                  zn_valid,
    output logic [DATA_WIDTH-1:0] xn,
    output logic [DATA_WIDTH-1:0] yn,
    output logic [DATA_WIDTH-1:0] zn,
    input  logic                  xn1_valid,
    input  logic                  yn1_valid,
    input  logic                  zn1_valid,
    input  logic [DATA_WIDTH-1:0] xn1,
    input  logic [DATA_WIDTH-1:0] yn1,
    input  logic [DATA_WIDTH-1:0] zn1,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_z,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
    logic [DATA_WIDTH-1:0] cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
    logic [DATA_WIDTH-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
    logic                  got_x_q, got_x_d, got_y_q, got_y_d, got_z_q, got_z_d;
    logic [CNT_WIDTH-1:0]  warm_q, warm_d, num_q, num_d;
    logic [CNT_WIDTH:0]    iter_q, iter_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  issue_vld_q, issue_vld_d;
    logic                  out_vld_q, out_vld_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

    // One extra bit keeps warmup+num_iter and the iteration count from wrapping.
    logic [CNT_WIDTH:0] run_len;
    logic [CNT_WIDTH:0] iter_inc;
    assign run_len  = {1'b0, warm_q} + {1'b0, num_q};
    assign iter_inc = iter_q + (CNT_WIDTH+1)'(1);

    always_comb begin
        state_d     = state_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        sz_d        = sz_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        cz_d        = cz_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        oz_d        = oz_q;
        got_x_d     = got_x_q;
        got_y_d     = got_y_q;
        got_z_d     = got_z_q;
        warm_d      = warm_q;
        num_d       = num_q;
        iter_d      = iter_q;
        timer_d     = timer_q;
        issue_vld_d = 1'b0;
        out_vld_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sx_d   = seed_x;
                    sy_d   = seed_y;
                    sz_d   = seed_z;
                    warm_d = warmup;
                    num_d  = num_iter;
                    iter_d = '0;
                    err_d  = 1'b0;
                    if (num_iter == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue_vld_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                got_x_d = 1'b0;
                got_y_d = 1'b0;
                got_z_d = 1'b0;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // First capture per channel wins; later repeats are dropped.
                if (xn1_valid && !got_x_q) begin
                    cx_d    = xn1;
                    got_x_d = 1'b1;
                end
                if (yn1_valid && !got_y_q) begin
                    cy_d    = yn1;
                    got_y_d = 1'b1;
                end
                if (zn1_valid && !got_z_q) begin
                    cz_d    = zn1;
                    got_z_d = 1'b1;
                end
                timer_d = timer_q + TW'(1);
                if (got_x_d && got_y_d && got_z_d) begin
                    state_d = S_UPDATE;
                end else if (timer_q == TW'(TIMEOUT - 2)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_UPDATE: begin
                sx_d   = cx_q;
                sy_d   = cy_q;
                sz_d   = cz_q;
                iter_d = iter_inc;
                if (iter_q >= {1'b0, warm_q}) begin
                    ox_d      = cx_q;
                    oy_d      = cy_q;
                    oz_d      = cz_q;
                    out_vld_d = 1'b1;
                end
                if (iter_inc == run_len) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    issue_vld_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            sz_q        <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            cz_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            oz_q        <= '0;
            got_x_q     <= 1'b0;
            got_y_q     <= 1'b0;
            got_z_q     <= 1'b0;
            warm_q      <= '0;
            num_q       <= '0;
            iter_q      <= '0;
            timer_q     <= '0;
            issue_vld_q <= 1'b0;
            out_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            sz_q        <= sz_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cz_q        <= cz_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            oz_q        <= oz_d;
            got_x_q     <= got_x_d;
            got_y_q     <= got_y_d;
            got_z_q     <= got_z_d;
            warm_q      <= warm_d;
            num_q       <= num_d;
            iter_q      <= iter_d;
            timer_q     <= timer_d;
            issue_vld_q <= issue_vld_d;
            out_vld_q   <= out_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign xn_valid  = issue_vld_q;
    assign yn_valid  = issue_vld_q;
    assign zn_valid  = issue_vld_q;
    assign xn        = sx_q;
    assign yn        = sy_q;
    assign zn        = sz_q;
    assign out_valid = out_vld_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;
    assign out_z     = oz_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/chaotic_iter_ctrl.md
# chaotic_iter_ctrl

Iteration sequencer that closes the feedback loop around the three chaotic-equation stages (x, y, z). It loads seed values, issues one (xn, yn, zn) triple per iteration to all three stages, collects the independently-timed xn1/yn1/zn1 results, and feeds them back as the next state. It discards a programmable number of warm-up iterations, streams the remaining states downstream, and detects a stalled pipeline with a timeout.

## Interface
- DATA_WIDTH, 64, state word width; must match the floating-point datapath width. Words are opaque bit patterns.
- CNT_WIDTH, 16, width of the iteration counters.
- TIMEOUT, 1024, maximum WAIT cycles before the error flag is raised; must exceed the worst stage latency.

- clk  in  1  clock; the block uses one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle run request; sampled only in IDLE.
- seed_x, seed_y, seed_z  in  DATA_WIDTH each  initial state, latched on start.
- warmup  in  CNT_WIDTH  iterations to discard; latched on start.
- num_iter  in  CNT_WIDTH  iterations to emit; latched on start.
- xn_valid, yn_valid, zn_valid  out  1 each  issue strobes to the stages; always identical.
- xn, yn, zn  out  DATA_WIDTH each  current state.
- xn1_valid, yn1_valid, zn1_valid  in  1 each  result strobes from the stages; may arrive on different cycles.
- xn1, yn1, zn1  in  DATA_WIDTH each  next-state results.
- out_valid  out  1  one-cycle strobe per emitted state.
- out_x, out_y, out_z  out  DATA_WIDTH each  emitted state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle strobe when a run completes normally.
- err  out  1  sticky timeout flag; cleared by reset or by the next accepted start.

## Operation
- All outputs are registered. On reset every output, the state registers and the counters are 0, and the FSM is in IDLE.
- **IDLE**
  - On start: latch the seeds into the state registers, latch warmup and num_iter, clear iter_cnt and err.
  - If num_iter == 0: pulse done and stay in IDLE. No issue strobes are driven.
  - Otherwise go to ISSUE.
- **ISSUE** (1 cycle)
  - Drive all three issue strobes high with xn/yn/zn equal to the state registers.
  - Clear the got_x/got_y/got_z flags and the timer.
  - Go to WAIT.
- **WAIT**
  - A result strobe whose got flag is clear captures its data and sets the flag.
  - A repeated strobe for an already-captured channel is ignored; the first capture wins.
  - Strobes arriving in any other state are ignored.
  - When all three flags are set, go to UPDATE. This includes the case where the last strobes arrive together in one cycle.
  - The timer increments every WAIT cycle. When it reaches TIMEOUT-1 without completion: set err, clear busy, go to IDLE, no done.
- **UPDATE** (1 cycle)
  - State registers take the captured triple; iter_cnt increments.
  - If the pre-increment iter_cnt >= warmup: load out_x/out_y/out_z with the new state and pulse out_valid.
  - If iter_cnt+1 == warmup + num_iter: pulse done and go to IDLE. This sum is computed in CNT_WIDTH+1 bits, so no wrap occurs.
  - Otherwise go to ISSUE.
- start while busy is ignored.
- An asynchronous reset mid-run returns the block to IDLE immediately. No done or out_valid is produced for the interrupted iteration.

## Timing
- start sampled at edge k. Issue strobes are high for exactly cycle k+1.
- The last result strobe sampled at edge m puts the FSM in UPDATE during cycle m+1.
- During cycle m+2, out_valid and done (when applicable) are high. The next ISSUE strobes are also high in m+2.
- Iteration period is L+2 cycles for a stage latency of L (last-arriving result).
- busy rises in cycle k+1. It falls in the same cycle that done or err is first visible.
- Exactly one issue strobe triple is outstanding at any time.

## Test plan
- Stub stages with fixed latency 5: xn1 = xn+1, yn1 = yn+2, zn1 = zn+3 (raw integer add). Seeds 0x10/0x20/0x30, warmup=0, num_iter=3.
  - Expect out triples (0x11,0x22,0x33), (0x12,0x24,0x36), (0x13,0x26,0x39).
  - out_valid spaced 7 cycles apart; done coincides with the third out_valid.
- Same stub with warmup=2, num_iter=2: expect exactly 2 out_valid, first triple (0x13,0x26,0x39). Total issue strobes = 4.
- Skewed latencies x=3, y=9, z=6 with the same stub: results are identical to the first scenario, and the period is 11 cycles.
- z stage never responds, TIMEOUT=16: err rises 16 cycles after ISSUE, with busy low and no done. A subsequent start clears err.
- num_iter=0: done pulses in cycle k+1, no issue strobes, busy stays 0. A start asserted during a run has no effect.
- Assert rst_n=0 during WAIT of iteration 2: all outputs are 0 while reset is held. A fresh start then reproduces the first scenario exactly.
